core_bus_ctrl: RTL and testbench



---
 rtl/core_bus_ctrl.sv | 124 ++++++++++++
 tb/tb_core_bus_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_ctrl.sv
// core_bus_ctrl
// -------------
// Bus controller sitting between the 8-bit core and slow external memory.
// Memory accesses are stretched by WAIT wait states. The core is stalled
// through 'hold' until the final cycle of an access. A 16-byte internal I/O
// window at IO_BASE is always served with zero wait states. The window holds
// a free-running tick counter, its high-byte shadow, a scratch byte and a
// read-only status byte.
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   address      in  16   core address (held stable while hold=1)
//   out          in   8   core write data
//   we           in   1   core write enable
//   in           out  8   read data to core (combinational)
//   hold         out  1   stall to core (combinational)
//   mem_address  out 16   external memory address (= address)
//   mem_out      out  8   external write data (= out)
//   mem_in       in   8   external read data
//   mem_we       out  1   external write strobe, one cycle per access
module core_bus_ctrl #(
  parameter int unsigned WAIT    = 2,
  parameter logic [15:0] IO_BASE = 16'hFFF0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  out,
  input  logic        we,
  output logic [7:0]  in,
  output logic        hold,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_out,
  input  logic [7:0]  mem_in,
  output logic        mem_we
);

  localparam logic [3:0] WaitVal = WAIT[3:0];

  logic        ioSel;
  logic        memSel;
  logic        isFinal;
  logic [3:0]  ioOffset;
  logic [3:0]  cntQ, cntD;
  logic [15:0] ticksQ, ticksD;
  logic [7:0]  shadowHiQ, shadowHiD;
  logic [7:0]  scratchQ, scratchD;

  assign ioSel    = (address[15:4] == IO_BASE[15:4]);
  assign memSel   = !ioSel;
  assign ioOffset = address[3:0];

  // I/O accesses finish in one cycle. Memory accesses finish when the
  // counter reaches WAIT. With WAIT=0 the counter therefore stays at zero
  // and hold can never rise.
  assign isFinal = ioSel | (cntQ == WaitVal);
  assign hold    = memSel & (cntQ != WaitVal);

  assign mem_address = address;
  assign mem_out     = out;

  // Gating with reset_n keeps the strobe quiet while reset is held. This
  // matters for the WAIT=0 build, where every memory cycle counts as final.
  assign mem_we = we & memSel & isFinal & reset_n;

  // Wait counter next state. A mid-access address change does not restart
  // the count, because only the current count and decode are used here.
  always_comb begin
    cntD = cntQ + 4'd1;
    if (ioSel || isFinal) begin
      cntD = 4'd0;
    end
  end

  // I/O register next state. A read of offset 0 (ticks low byte) snapshots
  // the high byte, so that a following read of offset 1 gives a coherent
  // 16-bit value.
  always_comb begin
    ticksD    = ticksQ + 16'd1;
    shadowHiD = shadowHiQ;
    scratchD  = scratchQ;
    if (ioSel) begin
      if (!we && ioOffset == 4'd0) begin
        shadowHiD = ticksQ[15:8];
      end
      if (we && ioOffset == 4'd2) begin
        scratchD = out;
      end
    end
  end

  // Read data mux. Memory data passes straight through on every memory
  // cycle. The core only consumes it in the final cycle.
  always_comb begin
    in = mem_in;
    if (ioSel) begin
      case (ioOffset)
        4'd0:    in = ticksQ[7:0];
        4'd1:    in = shadowHiQ;
        4'd2:    in = scratchQ;
        4'd3:    in = {4'h0, WaitVal};
        default: in = 8'hFF;
      endcase
    end
  end

  // All state clears asynchronously. An access caught by reset loses its
  // count and restarts from zero after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cntQ      <= 4'd0;
      ticksQ    <= 16'd0;
      shadowHiQ <= 8'd0;
      scratchQ  <= 8'd0;
    end else begin
      cntQ      <= cntD;
      ticksQ    <= ticksD;
      shadowHiQ <= shadowHiD;
      scratchQ  <= scratchD;
    end
  end

endmodule

// File: tb/tb_core_bus_ctrl.sv
// Self-checking bench for core_bus_ctrl. One instance uses WAIT=2 and a
// second uses WAIT=0 (pass-through). Inputs are driven on the falling edge
// and outputs are sampled shortly afterwards.
module tb_core_bus_ctrl;

  logic        clock;
  logic        reset_n;
  logic [15:0] address;
  logic [7:0]  out;
  logic        we;
  logic [7:0]  in;
  logic        hold;
  logic [15:0] memAddress;
  logic [7:0]  memOut;
  logic [7:0]  memIn;
  logic        memWe;

  logic [15:0] address0;
  logic [7:0]  out0;
  logic        we0;
  logic [7:0]  in0;
  logic        hold0;
  logic [15:0] memAddress0;
  logic [7:0]  memOut0;
  logic [7:0]  memIn0;
  logic        memWe0;

  int testsRun;
  int testsFailed;

  logic [7:0] memModel [0:65535];

  core_bus_ctrl #(.WAIT(2), .IO_BASE(16'hFFF0)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .out(out), .we(we),
    .in(in), .hold(hold), .mem_address(memAddress), .mem_out(memOut),
    .mem_in(memIn), .mem_we(memWe)
  );

  core_bus_ctrl #(.WAIT(0), .IO_BASE(16'hFFF0)) dut0 (
    .clock(clock), .reset_n(reset_n), .address(address0), .out(out0), .we(we0),
    .in(in0), .hold(hold0), .mem_address(memAddress0), .mem_out(memOut0),
    .mem_in(memIn0), .mem_we(memWe0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The external memory model captures writes strobed by the WAIT=2 instance.
  always @(posedge clock) begin
    if (memWe) memModel[memAddress] <= memOut;
  end

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wen;
    logic [7:0]  mIn;
    logic        expHold;
    logic        expMemWe;
    logic [7:0]  expIn;
  } vec_t;

  vec_t vecs [18];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic w, input logic [7:0] m);
    @(negedge clock);
    address = a;
    out     = d;
    we      = w;
    memIn   = m;
    #1;
  endtask

  task automatic checkCycle(input string name, input logic expHold, input logic expMemWe);
    checkOutput({name, ".hold"}, {15'd0, hold}, {15'd0, expHold});
    checkOutput({name, ".mem_we"}, {15'd0, memWe}, {15'd0, expMemWe});
  endtask

  // Watchdog, so that the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    //          name       addr      wdata  we    memIn  hold  memWe in
    vecs[0]  = '{"rd0",    16'h0100, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h5A};
    vecs[1]  = '{"rd1",    16'h0100, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h5A};
    vecs[2]  = '{"rd2",    16'h0100, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A};
    vecs[3]  = '{"wr0",    16'h0200, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{"wr1",    16'h0200, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{"wr2",    16'h0200, 8'hC3, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[6]  = '{"ioWr",   16'hFFF2, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{"ioRd",   16'hFFF2, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[8]  = '{"status", 16'hFFF3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h02};
    vecs[9]  = '{"unmap",  16'hFFF4, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[10] = '{"roWr",   16'hFFF5, 8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[11] = '{"ioRd2",  16'hFFF2, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[12] = '{"viol0",  16'h0100, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 8'h11};
    vecs[13] = '{"viol1",  16'h0400, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0, 8'h22};
    vecs[14] = '{"viol2",  16'h0400, 8'h00, 1'b0, 8'h33, 1'b0, 1'b0, 8'h33};
    vecs[15] = '{"edge0",  16'hFFEF, 8'h00, 1'b0, 8'h44, 1'b1, 1'b0, 8'h44};
    vecs[16] = '{"edge1",  16'hFFEF, 8'h00, 1'b0, 8'h44, 1'b1, 1'b0, 8'h44};
    vecs[17] = '{"edge2",  16'hFFEF, 8'h00, 1'b0, 8'h44, 1'b0, 1'b0, 8'h44};

    address = 16'h0100; out = 8'h99; we = 1'b1; memIn = 8'h5A;
    address0 = 16'h0010; out0 = 8'h99; we0 = 1'b1; memIn0 = 8'h00;
    reset_n = 1'b0;

    // Check the outputs while reset is held.
    #2;
    checkOutput("rst.hold", {15'd0, hold}, 16'd1);
    checkOutput("rst.mem_we", {15'd0, memWe}, 16'd0);
    checkOutput("rst.in", {8'd0, in}, 16'h005A);
    checkOutput("rst.hold0", {15'd0, hold0}, 16'd0);
    checkOutput("rst.mem_we0", {15'd0, memWe0}, 16'd0);
    address = 16'hFFF0; we = 1'b0;
    #1;
    checkOutput("rst.ioIn", {8'd0, in}, 16'h0000);
    checkOutput("rst.ioHold", {15'd0, hold}, 16'd0);
    we0 = 1'b0;
    address = 16'hFFF8;
    @(negedge clock);
    reset_n = 1'b1;

    // Run the table of single-cycle vectors.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wen, vecs[i].mIn);
      checkCycle(vecs[i].name, vecs[i].expHold, vecs[i].expMemWe);
      checkOutput({vecs[i].name, ".in"}, {8'd0, in}, {8'd0, vecs[i].expIn});
    end
    applyStimulus(16'hFFF8, 8'h00, 1'b0, 8'h00);
    checkOutput("mem0200", {8'd0, memModel[16'h0200]}, 16'h00C3);
    checkOutput("memAddr", memAddress, 16'hFFF8);

    // Check the tick counter and its shadow 300 clocks after reset.
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (300) @(posedge clock);
    applyStimulus(16'hFFF0, 8'h00, 1'b0, 8'h00);
    checkOutput("ticksLo", {8'd0, in}, 16'h002C);
    applyStimulus(16'hFFF1, 8'h00, 1'b0, 8'h00);
    checkOutput("shadowHi", {8'd0, in}, 16'h0001);

    // Preset the counter just below its maximum and watch it wrap.
    @(negedge clock);
    address = 16'hFFF0;
    force dut.ticksQ = 16'hFFFE;
    #1;
    release dut.ticksQ;
    #1;
    checkOutput("wrapFE", {8'd0, in}, 16'h00FE);
    applyStimulus(16'hFFF0, 8'h00, 1'b0, 8'h00);
    checkOutput("wrapFF", {8'd0, in}, 16'h00FF);
    applyStimulus(16'hFFF0, 8'h00, 1'b0, 8'h00);
    checkOutput("wrap00", {8'd0, in}, 16'h0000);
    applyStimulus(16'hFFF1, 8'h00, 1'b0, 8'h00);
    checkOutput("wrapHi", {8'd0, in}, 16'h0000);

    // Assert reset in the middle of a write. The aborted access must not
    // pulse mem_we. After release the access restarts with a full count.
    applyStimulus(16'hFFF8, 8'h00, 1'b0, 8'h00);
    applyStimulus(16'h0300, 8'h11, 1'b1, 8'h00);
    checkCycle("abort0", 1'b1, 1'b0);
    applyStimulus(16'h0300, 8'h11, 1'b1, 8'h00);
    checkCycle("abort1", 1'b1, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    checkCycle("abortRst", 1'b1, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkCycle("restart0", 1'b1, 1'b0);
    applyStimulus(16'h0300, 8'h11, 1'b1, 8'h00);
    checkCycle("restart1", 1'b1, 1'b0);
    applyStimulus(16'h0300, 8'h11, 1'b1, 8'h00);
    checkCycle("restart2", 1'b0, 1'b1);
    applyStimulus(16'hFFF8, 8'h00, 1'b0, 8'h00);
    checkCycle("afterWr", 1'b0, 1'b0);
    checkOutput("mem0300", {8'd0, memModel[16'h0300]}, 16'h0011);

    // Check that the WAIT=0 instance passes accesses straight through.
    @(negedge clock);
    address0 = 16'h0010; we0 = 1'b0; out0 = 8'h00; memIn0 = 8'h9E;
    #1;
    checkOutput("w0rd.hold", {15'd0, hold0}, 16'd0);
    checkOutput("w0rd.in", {8'd0, in0}, 16'h009E);
    checkOutput("w0rd.mem_we", {15'd0, memWe0}, 16'd0);
    @(negedge clock);
    we0 = 1'b1; out0 = 8'h44; memIn0 = 8'h00;
    #1;
    checkOutput("w0wr.hold", {15'd0, hold0}, 16'd0);
    checkOutput("w0wr.mem_we", {15'd0, memWe0}, 16'd1);
    checkOutput("w0wr.mem_out", {8'd0, memOut0}, 16'h0044);
    checkOutput("w0wr.mem_addr", memAddress0, 16'h0010);
    @(negedge clock);
    we0 = 1'b0; memIn0 = 8'h12;
    #1;
    checkOutput("w0rd2.hold", {15'd0, hold0}, 16'd0);
    checkOutput("w0rd2.in", {8'd0, in0}, 16'h0012);
    checkOutput("w0rd2.mem_we", {15'd0, memWe0}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
